// File: rtl/lfsr_seq_ctrl.sv
// Purpose : sequencing controller and state register for the board pseudo-random generator (LFSR taps 4,3,2,0).
// Latency : commands act on the next rising edge; in RUN an advance occurs every TICK_DIV cycles, first one TICK_DIV cycles after busy rises.
// Backpress: none; start/step are ignored while busy, load and stop are always accepted (load > stop > start/step).
//
// Ports:
//   clk, rst_n          - single clock, asynchronous active-low reset
//   din, load           - seed value and load command (returns to IDLE)
//   start, stop, step   - begin RUN / abort RUN / single manual advance
//   run_len             - advances per RUN captured at start, 0 = free-running
//   lfsr_q, step_cnt    - LFSR state and advances since last load/start (wraps)
//   busy, done          - RUN in progress / one-cycle pulse at end of bounded RUN
//
// Build option: define LFSR_CTRL_ZERO_GUARD_EN to keep the all-zero lock-up
// state out of the LFSR (zero seeds and zero reset seed become 1).

module lfsr_seq_ctrl #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           TICK_DIV   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_SEED = 'h01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  load,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic [7:0]            run_len,
  output logic [DATA_WIDTH-1:0] lfsr_q,
  output logic [7:0]            step_cnt,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

`ifdef LFSR_CTRL_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  localparam logic [DATA_WIDTH-1:0] ONE_VAL   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] SEED_INIT =
    (ZERO_GUARD && (RESET_SEED == '0)) ? ONE_VAL : RESET_SEED;
  // Prescaler terminal value; TICK_DIV=1 makes every RUN cycle a tick.
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] lfsr_d;
  logic [7:0]            step_cnt_q, step_cnt_d;
  logic [15:0]           presc_q, presc_d;
  logic [7:0]            len_q, len_d;
  logic                  done_q, done_d;

  logic                  tick;
  logic                  last_adv;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] step_val;
  logic [DATA_WIDTH-1:0] run_val;

  // Right shift with the feedback bit entering at the MSB.
  function automatic logic [DATA_WIDTH-1:0] lfsr_adv(input logic [DATA_WIDTH-1:0] q);
    logic fb;
    fb = q[4] ^ q[3] ^ q[2] ^ q[0];
    return {fb, q[DATA_WIDTH-1:1]};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED_INIT;
      step_cnt_q <= 8'd0;
      presc_q    <= 16'd0;
      len_q      <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      step_cnt_q <= step_cnt_d;
      presc_q    <= presc_d;
      len_q      <= len_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    step_cnt_d = step_cnt_q;
    presc_d    = presc_q;
    len_d      = len_q;
    done_d     = 1'b0;

    tick     = (presc_q == TICK_LAST);
    // step_cnt restarts at 0 on start, so the Nth advance is the one taken
    // while it still reads N-1.
    last_adv = (len_q != 8'd0) && (step_cnt_q == (len_q - 8'd1));
    load_val = (ZERO_GUARD && (din == '0)) ? ONE_VAL : din;
    step_val = lfsr_adv(lfsr_q);
    // A RUN that begins from zero is kicked to 1 on its first advance.
    run_val  = (ZERO_GUARD && (lfsr_q == '0)) ? ONE_VAL : step_val;

    if (load) begin
      state_d    = IDLE;
      lfsr_d     = load_val;
      step_cnt_d = 8'd0;
      presc_d    = 16'd0;
    end else if (stop) begin
      // Also swallows a same-cycle start/step when already idle.
      state_d = IDLE;
      presc_d = 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = RUN;
            len_d      = run_len;
            step_cnt_d = 8'd0;
            presc_d    = 16'd0;
          end else if (step) begin
            lfsr_d     = step_val;
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end
        RUN: begin
          if (tick) begin
            presc_d    = 16'd0;
            lfsr_d     = run_val;
            step_cnt_d = step_cnt_q + 8'd1;
            if (last_adv) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q == RUN);
    done     = done_q;
    step_cnt = step_cnt_q;
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Purpose : self-checking bench for lfsr_seq_ctrl with a per-cycle scoreboard and reference model.
// Latency : one expected entry per clock edge, compared 1 time unit after the edge.
// Backpress: none; stimulus and monitor are decoupled through the expectation queue.

module tb_lfsr_seq_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       load, start, stop, step;
  logic [7:0] run_len;
  logic [7:0] lfsr_q;
  logic [7:0] step_cnt;
  logic       busy, done;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(
    .DATA_WIDTH(8),
    .TICK_DIV  (TD),
    .RESET_SEED(8'h01)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .load    (load),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .run_len (run_len),
    .lfsr_q  (lfsr_q),
    .step_cnt(step_cnt),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [7:0] lfsr;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef LFSR_CTRL_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // Reference model: a running flag, total advances and cycles elapsed in RUN.
  logic [7:0] m_lfsr;
  int         m_adv;
  bit         m_run;
  int         m_len;
  int         m_cyc;
  bit         m_done;

  function automatic logic [7:0] ref_next(input logic [7:0] q);
    logic fb;
    fb = ^(q & 8'h1D);
    return (q >> 1) | (fb ? 8'h80 : 8'h00);
  endfunction

  task automatic model_reset();
    m_lfsr = 8'h01;
    m_adv  = 0;
    m_run  = 1'b0;
    m_len  = 0;
    m_cyc  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_apply(input bit l, input bit s, input bit st, input bit sp,
                             input logic [7:0] d, input logic [7:0] rl);
    m_done = 1'b0;
    if (l) begin
      m_lfsr = (GUARD && d == 8'h00) ? 8'h01 : d;
      m_adv  = 0;
      m_run  = 1'b0;
    end else if (s) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1'b1;
        m_len = int'(rl);
        m_adv = 0;
        m_cyc = 0;
      end else if (sp) begin
        m_lfsr = ref_next(m_lfsr);
        m_adv++;
      end
    end else begin
      m_cyc++;
      if (m_cyc % TD == 0) begin
        m_lfsr = (GUARD && m_lfsr == 8'h00) ? 8'h01 : ref_next(m_lfsr);
        m_adv++;
        if (m_len != 0 && m_adv == m_len) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock edge of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic cyc(input bit l, input bit s, input bit st, input bit sp,
                     input logic [7:0] d, input logic [7:0] rl);
    exp_t e;
    @(negedge clk);
    load = l; stop = s; start = st; step = sp; din = d; run_len = rl;
    model_apply(l, s, st, sp, d, rl);
    e.lfsr = m_lfsr;
    e.cnt  = 8'(m_adv % 256);
    e.busy = m_run;
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'($urandom), 8'($urandom));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset pulse started away from the clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    load = 1'b0; stop = 1'b0; start = 1'b0; step = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_lfsr"}, 32'(lfsr_q), 32'h01);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_cnt"},  32'(step_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: the DUT presents a new output set after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (lfsr_q !== e.lfsr || step_cnt !== e.cnt || busy !== e.busy || done !== e.done) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got lfsr=%02h cnt=%0d busy=%b done=%b expected lfsr=%02h cnt=%0d busy=%b done=%b",
                   $time, lfsr_q, step_cnt, busy, done, e.lfsr, e.cnt, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    logic [7:0] z_exp;
    rst_n = 1'b0;
    load = 1'b0; stop = 1'b0; start = 1'b0; step = 1'b0;
    din = 8'h00; run_len = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_lfsr", 32'(lfsr_q), 32'h01);
    chk("reset_cnt",  32'(step_cnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Manual steps from seed 1.
    cyc(1, 0, 0, 0, 8'h01, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 8'h00, 8'h00);
      idle(1);
    end
    settle();
    chk("step_lfsr", 32'(lfsr_q), 32'h88);
    chk("step_cnt",  32'(step_cnt), 32'd5);

    // Bounded run of 3 advances.
    cyc(1, 0, 0, 0, 8'h01, 8'h00);
    cyc(0, 0, 1, 0, 8'h00, 8'd3);
    idle(11);
    settle();
    chk("run3_busy_before_end", 32'(busy), 32'h1);
    idle(1);
    settle();
    chk("run3_lfsr", 32'(lfsr_q), 32'h20);
    chk("run3_cnt",  32'(step_cnt), 32'd3);
    chk("run3_busy", 32'(busy), 32'h0);
    chk("run3_done", 32'(done), 32'h1);
    idle(2);

    // Free-running, stop after 10 advances with a simultaneous start.
    cyc(1, 0, 0, 0, 8'h01, 8'h00);
    cyc(0, 0, 1, 0, 8'h00, 8'd0);
    idle(40);
    cyc(0, 1, 1, 0, 8'h00, 8'd5);
    settle();
    chk("free_cnt",  32'(step_cnt), 32'd10);
    chk("free_busy", 32'(busy), 32'h0);
    idle(6);

    // Load with stop in the middle of a run.
    cyc(0, 0, 1, 0, 8'h00, 8'd0);
    idle(7);
    cyc(1, 1, 0, 0, 8'hA5, 8'h00);
    settle();
    chk("midload_lfsr", 32'(lfsr_q), 32'hA5);
    chk("midload_cnt",  32'(step_cnt), 32'h0);
    chk("midload_busy", 32'(busy), 32'h0);
    idle(2);

    // Reset in the middle of a run.
    cyc(0, 0, 1, 0, 8'h00, 8'd9);
    idle(6);
    do_reset("midrst");
    idle(3);

    // Zero seed handling.
    z_exp = GUARD ? 8'h01 : 8'h00;
    cyc(1, 0, 0, 0, 8'h00, 8'h00);
    settle();
    chk("zero_load", 32'(lfsr_q), 32'(z_exp));
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'h00, 8'h00);
    settle();
    chk("zero_steps_lfsr", 32'(lfsr_q), GUARD ? 32'h88 : 32'h00);
    chk("zero_steps_cnt",  32'(step_cnt), 32'd5);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic       l, s, st, sp;
      logic [7:0] d, rl;
      l  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 4) == 0);
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 12));
      cyc(l, s, st, sp, d, rl);
      if (n % 700 == 350) do_reset("rndrst");
    end
    idle(2);
    settle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
